// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants, types and the per-register operation
// encoding for the parametrised register bank.
package regbank_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREGS = 4;

   typedef logic [DEF_WIDTH-1:0] reg_t;

   localparam reg_t ALL_ONES = '1;

   // Resolved per-register action for one clock edge
   typedef enum logic [1:0] {
      HOLD = 2'd0,
      LOAD = 2'd1,
      INC  = 2'd2,
      DEC  = 2'd3
   } regOp_t;

   // Load wins; inc and dec together cancel into a hold
   function automatic regOp_t decodeOp(input logic load, input logic inc, input logic dec);
      regOp_t op;
      if (load)
         op = LOAD;
      else if (inc && !dec)
         op = INC;
      else if (dec && !inc)
         op = DEC;
      else
         op = HOLD;
      return op;
   endfunction

endpackage

// File: rtl/regbank_cell.sv
// regbank_cell: one WIDTH-bit register with load/inc/dec priority and a
// registered wrap pulse. With REGBANK_SHADOW_EN defined it also carries a
// shadow register and a swap input that exchanges main and shadow.
module regbank_cell
   import regbank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             resetBar,
   input  logic             load,
   input  logic             inc,
   input  logic             dec,
`ifdef REGBANK_SHADOW_EN
   input  logic             swap,
`endif
   input  logic [WIDTH-1:0] dIn,
   output logic [WIDTH-1:0] q,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] mainQ;
   logic [WIDTH-1:0] baseVal;
   logic [WIDTH-1:0] nextVal;
   logic             wrapNext;
   logic             wrapQ;
   regOp_t           op;

`ifdef REGBANK_SHADOW_EN
   logic [WIDTH-1:0] shadowQ;

   // On a swap the arithmetic operates on the old shadow value
   assign baseVal = swap ? shadowQ : mainQ;
`else
   assign baseVal = mainQ;
`endif

   // Next value and wrap detection from the resolved operation
   always_comb begin
      op       = decodeOp(load, inc, dec);
      nextVal  = baseVal;
      wrapNext = 1'b0;
      case (op)
         LOAD: nextVal = dIn;
         INC: begin
            nextVal  = baseVal + ONE;
            wrapNext = (baseVal == ONES);
         end
         DEC: begin
            nextVal  = baseVal - ONE;
            wrapNext = (baseVal == '0);
         end
         default: nextVal = baseVal;
      endcase
   end

   // Main register and wrap pulse, cleared immediately by reset
   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         mainQ <= '0;
         wrapQ <= 1'b0;
      end else begin
         mainQ <= nextVal;
         wrapQ <= wrapNext;
      end
   end

`ifdef REGBANK_SHADOW_EN
   // Shadow takes the old main value whenever a swap happens
   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar)
         shadowQ <= '0;
      else if (swap)
         shadowQ <= mainQ;
   end
`endif

   assign q    = mainQ;
   assign wrap = wrapQ;

endmodule

// File: rtl/regbank_param.sv
// regbank_param: NREGS x WIDTH register bank with per-register load,
// increment and decrement, wrap pulses and a combinational bus-assert mux.
// The tristate is built above this block from dbus_out/dbus_oe.
// Optional feature macro: REGBANK_SHADOW_EN (adds swap port and shadow bank).
module regbank_param
   import regbank_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int WIDTH = DEF_WIDTH,
   parameter int SELW  = 4
) (
   input  logic                   clk,
   input  logic                   resetBar,
   input  logic [NREGS-1:0]       load,
   input  logic [NREGS-1:0]       inc,
   input  logic [NREGS-1:0]       dec,
`ifdef REGBANK_SHADOW_EN
   input  logic                   swap,
`endif
   input  logic                   assertEn,
   input  logic [SELW-1:0]        assertSel,
   input  logic [WIDTH-1:0]       dbus_in,
   output logic [WIDTH-1:0]       dbus_out,
   output logic                   dbus_oe,
   output logic [NREGS*WIDTH-1:0] regs,
   output logic [NREGS-1:0]       wrap
);

   logic [WIDTH-1:0] regArr [NREGS];

   for (genvar i = 0; i < NREGS; i++) begin : gCell
      regbank_cell #(
         .WIDTH (WIDTH)
      ) uCell (
         .clk      (clk),
         .resetBar (resetBar),
         .load     (load[i]),
         .inc      (inc[i]),
         .dec      (dec[i]),
`ifdef REGBANK_SHADOW_EN
         .swap     (swap),
`endif
         .dIn      (dbus_in),
         .q        (regArr[i]),
         .wrap     (wrap[i])
      );

      assign regs[i*WIDTH +: WIDTH] = regArr[i];
   end

   // Bus assert mux; out-of-range selects drive zero with the enable low
   always_comb begin
      dbus_out = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (assertSel == SELW'(i))
            dbus_out = regArr[i];
      end
      dbus_oe = assertEn && (32'(assertSel) < NREGS);
   end

endmodule

// File: tb/tb_regbank_param.sv
// tb_regbank_param: directed self-checking bench for regbank_param with
// default parameters (4 x 8 bits). Shadow checks need REGBANK_SHADOW_EN.
module tb_regbank_param;

   logic        clk;
   logic        resetBar;
   logic [3:0]  load;
   logic [3:0]  inc;
   logic [3:0]  dec;
`ifdef REGBANK_SHADOW_EN
   logic        swap;
`endif
   logic        assertEn;
   logic [3:0]  assertSel;
   logic [7:0]  dbus_in;
   logic [7:0]  dbus_out;
   logic        dbus_oe;
   logic [31:0] regs;
   logic [3:0]  wrap;

   int numCompared;
   int numMismatched;

   regbank_param #(
      .NREGS (4),
      .WIDTH (8),
      .SELW  (4)
   ) dut (
      .clk       (clk),
      .resetBar  (resetBar),
      .load      (load),
      .inc       (inc),
      .dec       (dec),
`ifdef REGBANK_SHADOW_EN
      .swap      (swap),
`endif
      .assertEn  (assertEn),
      .assertSel (assertSel),
      .dbus_in   (dbus_in),
      .dbus_out  (dbus_out),
      .dbus_oe   (dbus_oe),
      .regs      (regs),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numCompared++;
      if (got !== exp) begin
         numMismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load = '0;
      inc  = '0;
      dec  = '0;
`ifdef REGBANK_SHADOW_EN
      swap = 1'b0;
`endif
   endtask

   task automatic loadReg(input int idx, input logic [7:0] val);
      idle();
      load[idx] = 1'b1;
      dbus_in   = val;
      tick();
      idle();
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      resetBar  = 1'b0;
      idle();
      assertEn  = 1'b0;
      assertSel = '0;
      dbus_in   = '0;

      // Reset state
      #12;
      checkVal("reset_regs", regs, 32'h0);
      checkVal("reset_wrap", {28'h0, wrap}, 32'h0);
      @(negedge clk);
      resetBar = 1'b1;
      tick();
      checkVal("post_release_regs", regs, 32'h0);

      // Asynchronous reset in the middle of an increment run
      load    = 4'hF;
      dbus_in = 8'h5A;
      tick();
      checkVal("load_all_5a", regs, 32'h5A5A5A5A);
      load = '0;
      inc  = 4'hF;
      tick();
      checkVal("inc_all_5b", regs, 32'h5B5B5B5B);
      #2;
      resetBar = 1'b0;
      #1;
      checkVal("async_reset_regs", regs, 32'h0);
      checkVal("async_reset_wrap", {28'h0, wrap}, 32'h0);
      idle();
      @(negedge clk);
      resetBar = 1'b1;
      tick();
      checkVal("after_async_reset", regs, 32'h0);

      // Multi-load and assertion
      loadReg(1, 8'h77);
      loadReg(3, 8'h77);
      load    = 4'b0101;
      dbus_in = 8'h3C;
      tick();
      idle();
      checkVal("multi_load", regs, 32'h773C773C);
      assertEn  = 1'b1;
      assertSel = 4'd2;
      #1;
      checkVal("assert2_oe", {31'h0, dbus_oe}, 32'h1);
      checkVal("assert2_out", {24'h0, dbus_out}, 32'h3C);
      assertSel = 4'd1;
      #1;
      checkVal("assert1_out", {24'h0, dbus_out}, 32'h77);
      assertSel = 4'd5;
      #1;
      checkVal("assert5_oe", {31'h0, dbus_oe}, 32'h0);
      checkVal("assert5_out", {24'h0, dbus_out}, 32'h0);
      assertEn  = 1'b0;
      assertSel = 4'd2;
      #1;
      checkVal("assert_dis_oe", {31'h0, dbus_oe}, 32'h0);

      // Increment wrap on reg3
      loadReg(3, 8'hFE);
      inc[3] = 1'b1;
      tick();
      checkVal("inc_ff", {24'h0, regs[31:24]}, 32'hFF);
      checkVal("inc_ff_wrap", {28'h0, wrap}, 32'h0);
      tick();
      checkVal("inc_00", {24'h0, regs[31:24]}, 32'h00);
      checkVal("inc_00_wrap", {28'h0, wrap}, 32'h8);
      tick();
      checkVal("inc_01", {24'h0, regs[31:24]}, 32'h01);
      checkVal("inc_01_wrap", {28'h0, wrap}, 32'h0);
      idle();

      // Priority on reg1
      loadReg(1, 8'h10);
      load[1] = 1'b1;
      inc[1]  = 1'b1;
      dbus_in = 8'h80;
      tick();
      checkVal("load_over_inc", {24'h0, regs[15:8]}, 32'h80);
      checkVal("load_over_inc_wrap", {28'h0, wrap}, 32'h0);
      load[1] = 1'b0;
      dec[1]  = 1'b1;
      tick();
      checkVal("inc_dec_hold", {24'h0, regs[15:8]}, 32'h80);
      idle();
      loadReg(1, 8'h00);
      dec[1] = 1'b1;
      tick();
      checkVal("dec_ff", {24'h0, regs[15:8]}, 32'hFF);
      checkVal("dec_ff_wrap", {28'h0, wrap}, 32'h2);
      idle();
      tick();
      checkVal("wrap_one_cycle", {28'h0, wrap}, 32'h0);
      loadReg(1, 8'h00);
      checkVal("load_no_wrap_val", {24'h0, regs[15:8]}, 32'h00);
      checkVal("load_no_wrap", {28'h0, wrap}, 32'h0);

      // Same-cycle assert and load of reg0
      loadReg(0, 8'h11);
      assertEn  = 1'b1;
      assertSel = 4'd0;
      load[0]   = 1'b1;
      dbus_in   = 8'h22;
      #1;
      checkVal("assert_load_pre", {24'h0, dbus_out}, 32'h11);
      tick();
      idle();
      checkVal("assert_load_post", {24'h0, dbus_out}, 32'h22);
      assertEn = 1'b0;

`ifdef REGBANK_SHADOW_EN
      // Shadow swap: shadow is still zero since the last reset
      loadReg(0, 8'h01);
      loadReg(1, 8'h02);
      loadReg(2, 8'h03);
      loadReg(3, 8'h04);
      checkVal("shadow_main_init", regs, 32'h04030201);
      swap    = 1'b1;
      load[0] = 1'b1;
      dbus_in = 8'h99;
      tick();
      idle();
      checkVal("swap1_main", regs, 32'h00000099);
      swap = 1'b1;
      tick();
      idle();
      checkVal("swap2_main", regs, 32'h04030201);
      swap = 1'b1;
      tick();
      idle();
      checkVal("swap3_main", regs, 32'h00000099);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule

// File: doc/regbank_param.md
Name: regbank_param

Overview:
- Parametrised successor to the fixed four-register A/B/X/Q file, replacing four hard-wired 8-bit GPRs.
- Provides NREGS registers of WIDTH bits, all loaded from the data bus on the clock edge.
- Adds per-register increment and decrement (index/counter use), a registered wrap pulse, and selectable bus assertion of any register.
- Sits between the control decoder and the data bus. Drives the bus via an explicit value/output-enable pair; the top level builds the tristate.

Parameters:
- NREGS, 4, number of registers (2..16).
- WIDTH, 8, register and bus width in bits.
- SELW, 4, width of the assert-select field; must satisfy 2^SELW >= NREGS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetBar  input  1  asynchronous, active-low reset.
- load  input  NREGS  per-register load enable; register i takes dbus_in.
- inc  input  NREGS  per-register increment enable.
- dec  input  NREGS  per-register decrement enable.
- assertEn  input  1  request to drive the bus with the selected register.
- assertSel  input  SELW  index of the register to assert.
- dbus_in  input  WIDTH  current data-bus value.
- dbus_out  output  WIDTH  value to drive onto the bus.
- dbus_oe  output  1  bus output enable.
- regs  output  NREGS*WIDTH  flat view of all registers; register i occupies bits [i*WIDTH +: WIDTH].
- wrap  output  NREGS  one-cycle pulse when register i wrapped on the previous edge.

Behaviour:
- Reset: while resetBar=0, every register is 0 and wrap=0. Reset is asynchronous: it takes effect immediately, including in the middle of an inc/dec sequence. The first update after release is the first rising edge with resetBar=1.
- Per-register priority at each rising edge, highest first:
  - load[i]=1: reg = dbus_in.
  - else inc[i]=1 and dec[i]=0: reg = reg+1, modulo 2^WIDTH.
  - else dec[i]=1 and inc[i]=0: reg = reg-1, modulo 2^WIDTH.
  - else (including inc[i]=dec[i]=1): hold.
- Multiple load bits set in one cycle: every selected register captures the same dbus_in value.
- Wrap pulse:
  - wrap[i] goes to 1 for exactly one cycle after an edge on which inc took all-ones to 0, or dec took 0 to all-ones.
  - No wrap pulse when a load produces that transition.
  - Otherwise wrap[i]=0.
- Bus assertion is combinational with zero latency:
  - dbus_oe = assertEn && (assertSel < NREGS).
  - dbus_out = regs[assertSel] when assertSel is in range, else 0.
- Asserting a register while it is being loaded: dbus_out shows the pre-edge value. The new value is visible in the cycle after the edge.
- The block never checks for or prevents assert-and-load of the same register. The top level must not create that bus loop.
- regs is a registered output with no combinational path from the inputs.

Optional Feature:
- Macro: REGBANK_SHADOW_EN.
- When defined:
  - Add input swap (1 bit) and a shadow bank of NREGS x WIDTH, reset to 0.
  - On an edge with swap=1, main and shadow exchange in one cycle.
  - Register i ends as: dbus_in if load[i]; else old shadow[i] +/- 1 per inc/dec; else old shadow[i]. The new shadow[i] is the old main[i].
  - Wrap is evaluated on the value being incremented or decremented (old shadow).
- When not defined: no swap port, no shadow storage, behaviour exactly as above.

Decomposition:
- Package regbank_pkg holds:
  - default WIDTH/NREGS constants;
  - typedef reg_t (logic [WIDTH-1:0]);
  - localparam ALL_ONES;
  - the inc/dec/load priority encoding as an enum {HOLD, LOAD, INC, DEC}.
- One sub-module, regbank_cell: a single register with load/inc/dec priority, wrap detection and an optional shadow swap port. It is instantiated NREGS times by generate.
- regbank_param itself contains only the generate loop, the assert mux and the port flattening.

Test Plan:
- Reset: drive resetBar=0 mid-run with regs holding 8'h5A -> all regs and wrap go to 0 immediately, without waiting for a clk edge.
- Load/assert: load=4'b0101, dbus_in=8'h3C, one edge -> reg0=reg2=8'h3C, reg1=reg3 unchanged. Then assertEn=1, assertSel=2 -> dbus_oe=1, dbus_out=8'h3C. Then assertSel=5 -> dbus_oe=0.
- Increment wrap: load reg3=8'hFE, inc[3]=1 for 3 edges -> reg3 values FF, 00, 01; wrap[3]=1 only in the cycle after the FF->00 edge.
- Priority: reg1=8'h10, load[1]=inc[1]=1, dbus_in=8'h80 -> 8'h80 with no wrap. Then inc[1]=dec[1]=1 -> holds 8'h80. Then dec[1] alone from 8'h00 -> FF with wrap[1] pulse.
- Same-cycle assert+load: reg0=8'h11, assertSel=0, load[0]=1, dbus_in=8'h22 -> dbus_out=8'h11 before the edge and 8'h22 after.
- Shadow (REGBANK_SHADOW_EN): main={1,2,3,4}, shadow={0,0,0,0}, swap=1 with load[0]=1, dbus_in=8'h99 -> main={99,0,0,0}, shadow={1,2,3,4}. A second swap restores main={1,2,3,4}, shadow={99,0,0,0}.
